// File: rtl/sg_list_reader_gen.sv
// Scatter-gather list reader: assembles 128-bit SG elements (addr_lo, addr_hi, len, rsvd) from
// 32/64/128-bit FIFO beats and presents them through a small element queue.
module sg_list_reader_gen #(
    parameter int C_DATA_WIDTH = 128,
    parameter int C_ELEM_DEPTH = 2,
    parameter int C_SKIP_ZERO  = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [C_DATA_WIDTH-1:0] BUF_DATA,
    input  logic                    BUF_DATA_EMPTY,
    output logic                    BUF_DATA_REN,
    input  logic                    FLUSH,
    output logic                    VALID,
    output logic                    EMPTY,
    input  logic                    REN,
    output logic [63:0]             ADDR,
    output logic [31:0]             LEN,
    output logic [15:0]             ELEM_COUNT
);

    localparam int BEATS = 128 / C_DATA_WIDTH;
    localparam int PTR_W = (C_ELEM_DEPTH > 1) ? $clog2(C_ELEM_DEPTH) : 1;
    localparam int MEM_N = 1 << PTR_W;
    localparam int CNT_W = $clog2(C_ELEM_DEPTH + 1);
    localparam logic [1:0]       LAST_BEAT = 2'(BEATS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(C_ELEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(C_ELEM_DEPTH);

    generate
        if (!(C_DATA_WIDTH == 32 || C_DATA_WIDTH == 64 || C_DATA_WIDTH == 128) ||
            !(C_ELEM_DEPTH == 1 || C_ELEM_DEPTH == 2 || C_ELEM_DEPTH == 4)) begin : gIllegal
            $error("sg_list_reader_gen: illegal C_DATA_WIDTH=%0d or C_ELEM_DEPTH=%0d",
                   C_DATA_WIDTH, C_ELEM_DEPTH);
        end
    endgenerate

    logic [1:0]       rBeat;
    logic [127:0]     rAsm;
    logic [63:0]      rMemAddr [MEM_N];
    logic [31:0]      rMemLen  [MEM_N];
    logic [PTR_W-1:0] rRdPtr;
    logic [PTR_W-1:0] rWrPtr;
    logic [CNT_W-1:0] rCount;
    logic [63:0]      rHoldAddr;
    logic [31:0]      rHoldLen;
    logic [15:0]      rElemCount;

    logic [127:0]     wAsm;
    logic             wLast;
    logic             wZero;
    logic             wSpace;
    logic             wPop;
    logic             wEnq;
    logic [PTR_W-1:0] wRdNext;
    logic [PTR_W-1:0] wWrNext;

    always_comb begin
        // Current beat overlaid on the partially assembled element.
        wAsm = rAsm;
        for (int b = 0; b < BEATS; b++) begin
            if (rBeat == 2'(b)) begin
                wAsm[b*C_DATA_WIDTH +: C_DATA_WIDTH] = BUF_DATA;
            end
        end
        wLast        = (rBeat == LAST_BEAT);
        wZero        = (C_SKIP_ZERO != 0) && (wAsm[95:64] == 32'd0);
        VALID        = (rCount != '0);
        wPop         = VALID && REN && !FLUSH;
        wSpace       = (rCount < DEPTH_CNT) || (VALID && REN);
        BUF_DATA_REN = !RST && !BUF_DATA_EMPTY && !FLUSH && (!wLast || wSpace || wZero);
        wEnq         = BUF_DATA_REN && wLast && !wZero;
        wRdNext      = (rRdPtr == LAST_PTR) ? '0 : rRdPtr + 1'b1;
        wWrNext      = (rWrPtr == LAST_PTR) ? '0 : rWrPtr + 1'b1;
        EMPTY        = (rCount == '0) && (rBeat == 2'd0);
        ADDR         = VALID ? rMemAddr[rRdPtr] : rHoldAddr;
        LEN          = VALID ? rMemLen[rRdPtr]  : rHoldLen;
        ELEM_COUNT   = rElemCount;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rBeat      <= 2'd0;
            rAsm       <= '0;
            rRdPtr     <= '0;
            rWrPtr     <= '0;
            rCount     <= '0;
            rHoldAddr  <= '0;
            rHoldLen   <= '0;
            rElemCount <= '0;
            for (int i = 0; i < MEM_N; i++) begin
                rMemAddr[i] <= '0;
                rMemLen[i]  <= '0;
            end
        end else begin
            if (FLUSH) begin
                rBeat  <= 2'd0;
                rRdPtr <= '0;
                rWrPtr <= '0;
                rCount <= '0;
            end else begin
                if (BUF_DATA_REN) begin
                    rAsm  <= wAsm;
                    rBeat <= wLast ? 2'd0 : rBeat + 2'd1;
                end
                if (wEnq) begin
                    rMemAddr[rWrPtr] <= wAsm[63:0];
                    rMemLen[rWrPtr]  <= wAsm[95:64];
                    rWrPtr           <= wWrNext;
                end
                if (wPop) begin
                    rRdPtr     <= wRdNext;
                    rElemCount <= rElemCount + 16'd1;
                end
                rCount <= rCount + CNT_W'(wEnq) - CNT_W'(wPop);
            end
            // Remember the visible head so outputs hold it once the queue drains.
            if (VALID) begin
                rHoldAddr <= ADDR;
                rHoldLen  <= LEN;
            end
        end
    end

endmodule
